// File: rtl/div_unit.sv
// Multicycle signed restoring divider for the MIPS div instruction.
// Produces one quotient bit per cycle and returns the quotient on lo and the remainder on hi.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on a start edge
// RUN   | one restoring shift/subtract step per cycle, WIDTH steps in total
// FIX   | applies the result signs and loads hi/lo
// DONE  | single-cycle completion; div_zero marks the divide-by-zero path
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r, zero_q;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] trial;
    logic             fits;

    always_comb begin
        dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
        rem_sh       = {rem, quo[WIDTH-1]};
        fits         = (rem_sh >= {1'b0, dvsr});
        // When the trial fits, the difference is below dvsr, so WIDTH bits hold it.
        trial        = rem_sh[WIDTH-1:0] - dvsr;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == RUN) || (state == FIX);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && zero_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            zero_q <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            zero_q <= 1'b1;
                        end else begin
                            zero_q <= 1'b0;
                            quo    <= dividend_abs;
                            dvsr   <= divisor_abs;
                            rem    <= '0;
                            cnt    <= CNT_W'(WIDTH - 1);
                            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r <= dividend[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    rem <= fits ? trial : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    lo <= sign_q ? -quo : quo;
                    hi <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule
